fp_wb_arbiter: RTL and testbench

FP_WB_ARBITER -- requirements
Module: fp_wb_arbiter

---
 rtl/fp_wb_pkg.sv | 22 ++
 rtl/fp_wb_fifo.sv | 57 +++++
 rtl/fp_wb_arbiter.sv | 84 ++++++++
 tb/tb_fp_wb_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_wb_pkg.sv
// Shared types for the FP register-file writeback arbiter.
// The request struct is the element stored in each per-source queue.
package fp_wb_pkg;

  localparam int FP_WB_DEPTH_DEFAULT = 2;

  typedef logic [4:0] fp_reg_idx_t;

  typedef struct packed {
    fp_reg_idx_t addr;
    logic [63:0] data;
  } fp_wb_req_t;

  // The register file drops a write whose address matches any live read port.
  function automatic logic fp_wb_read_hit(input fp_reg_idx_t a,
                                          input fp_reg_idx_t r1,
                                          input fp_reg_idx_t r2,
                                          input fp_reg_idx_t r3);
    return (a == r1) || (a == r2) || (a == r3);
  endfunction

endpackage

// File: rtl/fp_wb_fifo.sv
// Per-source request queue: DEPTH entries, registered-count ready, head exposed
// combinationally so the arbiter can check it against the read ports.
module fp_wb_fifo
  import fp_wb_pkg::*;
#(
  parameter int DEPTH = FP_WB_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  fp_wb_req_t             i_din,
  input  logic                   i_pop,
  output fp_wb_req_t             o_head,
  output logic                   o_ready,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  fp_wb_req_t    r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  // A full queue refuses pushes even when the head pops in the same cycle.
  assign o_ready   = (r_count < CW'(DEPTH));
  assign w_do_push = i_push && o_ready;
  assign w_do_pop  = i_pop && (r_count != '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is intentionally left unreset; only pointers and count matter.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/fp_wb_arbiter.sv
// Two-source FP register-file writeback arbiter. Each source queues results;
// a head issues only when it cannot collide with a live read port.
module fp_wb_arbiter
  import fp_wb_pkg::*;
#(
  parameter int DEPTH = FP_WB_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic [4:0]  s0_addr,
  input  logic [63:0] s0_data,
  input  logic        s1_valid,
  output logic        s1_ready,
  input  logic [4:0]  s1_addr,
  input  logic [63:0] s1_data,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  input  logic [4:0]  raddr3,
  output logic        wen,
  output logic [4:0]  waddr,
  output logic [63:0] wdata,
  output logic        wsrc,
  output logic        busy
);

  localparam int NSRC = 2;
  localparam int CW   = $clog2(DEPTH) + 1;

  fp_wb_req_t        w_din   [NSRC];
  fp_wb_req_t        w_head  [NSRC];
  logic [CW-1:0]     w_count [NSRC];
  logic [NSRC-1:0]   w_valid;
  logic [NSRC-1:0]   w_ready;
  logic [NSRC-1:0]   w_pop;
  logic [NSRC-1:0]   w_elig;
  logic              w_gnt_vld;
  logic              w_gnt_src;
  logic              r_last;

  assign w_din[0] = '{addr: s0_addr, data: s0_data};
  assign w_din[1] = '{addr: s1_addr, data: s1_data};
  assign w_valid  = {s1_valid, s0_valid};
  assign s0_ready = w_ready[0];
  assign s1_ready = w_ready[1];

  for (genvar g = 0; g < NSRC; g++) begin : gen_q
    fp_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_valid[g]),
      .i_din   (w_din[g]),
      .i_pop   (w_pop[g]),
      .o_head  (w_head[g]),
      .o_ready (w_ready[g]),
      .o_count (w_count[g])
    );

    assign w_elig[g] = (w_count[g] != '0) &&
                       !fp_wb_read_hit(w_head[g].addr, raddr1, raddr2, raddr3);
    assign w_pop[g]  = w_gnt_vld && (w_gnt_src == 1'(g));
  end

  // Tie goes to the source that did not win last; r_last resets to 1 so s0 wins first.
  always_comb begin
    w_gnt_vld = |w_elig;
    w_gnt_src = 1'b0;
    if (&w_elig)        w_gnt_src = ~r_last;
    else if (w_elig[1]) w_gnt_src = 1'b1;
  end

  assign wen   = w_gnt_vld;
  assign wsrc  = w_gnt_vld ? w_gnt_src : 1'b0;
  assign waddr = w_gnt_vld ? w_head[w_gnt_src].addr : 5'd0;
  assign wdata = w_gnt_vld ? w_head[w_gnt_src].data : 64'd0;
  assign busy  = (w_count[0] != '0) || (w_count[1] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_last <= 1'b1;
    else if (w_gnt_vld) r_last <= w_gnt_src;
  end

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Directed bench for fp_wb_arbiter: reset state, fairness, read-port stalls,
// back-pressure, mid-flight reset and steady push/pop streaming.
module tb_fp_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s0_valid, s1_valid, s0_ready, s1_ready;
  logic [4:0]  s0_addr, s1_addr, raddr1, raddr2, raddr3, waddr;
  logic [63:0] s0_data, s1_data, wdata;
  logic        wen, wsrc, busy;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] ONE = 64'h3FF0000000000000;

  fp_wb_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
    .raddr1(raddr1), .raddr2(raddr2), .raddr3(raddr3),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wsrc(wsrc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s0_valid = 0; s1_valid = 0;
    s0_addr = 0; s1_addr = 0; s0_data = 0; s1_data = 0;
    raddr1 = 0; raddr2 = 0; raddr3 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_wen"},  wen,  0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic chk_wr(input string tag, input logic src, input logic [4:0] a, input logic [63:0] d);
    chk({tag, "_wen"},   wen,   1);
    chk({tag, "_wsrc"},  wsrc,  src);
    chk({tag, "_waddr"}, waddr, a);
    chk({tag, "_wdata"}, wdata, d);
  endtask

  // Fill both queues with two entries each while read ports block their heads.
  task automatic fill_both();
    raddr1 = 5'd10; raddr2 = 5'd20;
    s0_valid = 1; s0_addr = 5'd10; s0_data = 64'hA0;
    s1_valid = 1; s1_addr = 5'd20; s1_data = 64'hB0;
    tick();
    s0_addr = 5'd11; s0_data = 64'hA1;
    s1_addr = 5'd21; s1_data = 64'hB1;
    tick();
    s0_valid = 0; s1_valid = 0;
    #1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    #2;
    chk("rst_wen",   wen,   0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wsrc",  wsrc,  0);
    chk("rst_busy",  busy,  0);
    chk("rst_rdy0",  s0_ready, 1);
    chk("rst_rdy1",  s1_ready, 1);
    tick();
    rst_n = 1;

    // single write, one cycle after acceptance
    tick();
    s0_valid = 1; s0_addr = 5'd3; s0_data = ONE;
    #1;
    chk("t1_nocomb", wen, 0);
    tick();
    s0_valid = 0;
    #1;
    chk_wr("t1", 0, 5'd3, ONE);
    chk("t1_busy", busy, 1);
    tick();
    chk_idle("t1_end");

    // round-robin between two full queues
    do_reset();
    fill_both();
    chk("t2_rdy0", s0_ready, 0);
    chk("t2_rdy1", s1_ready, 0);
    chk("t2_blk",  wen, 0);
    raddr1 = 0; raddr2 = 0;
    #1;
    chk_wr("t2_c0", 0, 5'd10, 64'hA0); tick();
    chk_wr("t2_c1", 1, 5'd20, 64'hB0); tick();
    chk_wr("t2_c2", 0, 5'd11, 64'hA1); tick();
    chk_wr("t2_c3", 1, 5'd21, 64'hB1); tick();
    chk_idle("t2_end");

    // read-port stall on s0 head; s1 bypasses
    do_reset();
    raddr2 = 5'd5;
    s0_valid = 1; s0_addr = 5'd5; s0_data = 64'h55;
    s1_valid = 1; s1_addr = 5'd6; s1_data = 64'h66;
    tick();
    s0_valid = 0; s1_valid = 0;
    #1;
    chk_wr("t3_s1", 1, 5'd6, 64'h66);
    tick();
    chk("t3_stall1", wen, 0);
    chk("t3_busy",   busy, 1);
    tick();
    chk("t3_stall2", wen, 0);
    raddr2 = 0;
    #1;
    chk_wr("t3_s0", 0, 5'd5, 64'h55);
    tick();
    chk_idle("t3_end");

    // back-pressure: third push waits for ready, order preserved
    do_reset();
    raddr1 = 5'd7;
    s0_valid = 1; s0_addr = 5'd7; s0_data = 64'hC7;
    #1;
    chk("t4_rdy_a", s0_ready, 1);
    tick();
    s0_addr = 5'd8; s0_data = 64'hC8;
    tick();
    s0_addr = 5'd9; s0_data = 64'hC9;
    #1;
    chk("t4_full", s0_ready, 0);
    chk("t4_blk",  wen, 0);
    tick();
    chk("t4_held", s0_ready, 0);
    raddr1 = 0;
    #1;
    chk_wr("t4_w7", 0, 5'd7, 64'hC7);
    chk("t4_popfull", s0_ready, 0);
    tick();
    chk("t4_rdy_b", s0_ready, 1);
    chk_wr("t4_w8", 0, 5'd8, 64'hC8);
    tick();
    s0_valid = 0;
    #1;
    chk_wr("t4_w9", 0, 5'd9, 64'hC9);
    tick();
    chk_idle("t4_end");

    // reset with entries queued
    do_reset();
    fill_both();
    chk("t5_busy_pre", busy, 1);
    #2;
    rst_n = 0;
    #1;
    chk("t5_wen",  wen, 0);
    chk("t5_busy", busy, 0);
    chk("t5_rdy0", s0_ready, 1);
    chk("t5_rdy1", s1_ready, 1);
    raddr1 = 0; raddr2 = 0;
    tick();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t5_nowr%0d", i), wen, 0);
    end

    // streaming push/pop on s1 at count=1
    do_reset();
    s1_valid = 1; s1_addr = 5'd2; s1_data = 64'd100;
    tick();
    for (int k = 0; k < 10; k++) begin
      s1_data = 64'd101 + 64'(k);
      #1;
      chk_wr($sformatf("t6_c%0d", k), 1, 5'd2, 64'd100 + 64'(k));
      chk($sformatf("t6_cnt%0d", k), 64'(dut.w_count[1]), 1);
      chk($sformatf("t6_rdy%0d", k), s1_ready, 1);
      tick();
    end
    s1_valid = 0;
    #1;
    chk_wr("t6_last", 1, 5'd2, 64'd110);
    tick();
    chk_idle("t6_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
